keypad_scan_encoder: RTL and testbench
======================================

// Module: keypad_scan_encoder
// PURPOSE
//  Scans a 4x4 matrix keypad and encodes the pressed key into a 4-bit code.
//  Sits between the keypad pins and the hex 7-segment display driver.
//  key_code feeds the display's 4-bit input directly; key_valid/key_held
//  go to downstream logic. One key per press; synchronised, debounced.
// PARAMETERS
//  SCAN_DIV  1000   clk cycles each column is driven per scan step (>=3)
//  DEBOUNCE  50000  consecutive stable cycles required for press/release (>=1)
// PORTS
//  clk        in   1  system clock; all state on rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  row_n      in   4  keypad rows, active-low (pulled up), asynchronous to clk
//  col_n      out  4  keypad columns, active-low, one-hot-zero drive
//  key_code   out  4  code of the last accepted key; held until next accept
//  key_valid  out  1  one-cycle pulse when a new key is accepted
//  key_held   out  1  high from accept until debounced release
// BEHAVIOUR
//  Reset (async assert, sync release): col_n=4'b1110, key_code=0,
//   key_valid=0, key_held=0, state=SCAN, col_idx=0, counters=0, sync FFs=4'hF.
//  Input sync: row_n passes 2 flops -> rows_s (2-cycle latency).
//   All decisions use rows_s only.
//  col_n = ~(1<<col_idx); it changes only in SCAN on column advance.
//  Counters sized $clog2(max(SCAN_DIV,DEBOUNCE))+1; no wrap in use.
//  SCAN: dwell counter 0..SCAN_DIV-1. At the terminal count:
//   - If rows_s!=4'hF: latch row=lowest-index low bit, col=col_idx;
//     go DEBOUNCE, clear counter, keep col_n.
//   - Else: col_idx+1 (3 wraps to 0), counter restarts.
//  DEBOUNCE: while rows_s[row]==0, count up.
//   - Counter reaching DEBOUNCE-1 -> HELD. Next cycle: key_code=map(row,col),
//     key_valid=1 for exactly one cycle, key_held=1.
//   - rows_s[row]==1 before that: abort to SCAN, col_idx+1, no outputs change.
//  HELD: col_n held; other rows/keys ignored.
//   - rows_s[row]==1 -> RELEASE, counter cleared.
//  RELEASE: rows_s[row]==1 counts up.
//   - Counter reaching DEBOUNCE-1 -> key_held=0, SCAN, col_idx+1.
//   - rows_s[row]==0 before that -> back to HELD, counter cleared,
//     no new key_valid.
//  Key map (row r, col c -> code):
//   r0: 1 2 3 A
//   r1: 4 5 6 B
//   r2: 7 8 9 C
//   r3: E 0 F D   (* -> E, # -> F)
//  key_code is registered; it retains its value through SCAN and across
//   releases, and changes only together with key_valid.
//  Multiple low rows in the driven column: lowest row index wins.
//  Reset asserted in any state: outputs return to reset values immediately;
//   a pending press is discarded, no key_valid.
// TESTING (SCAN_DIV=4, DEBOUNCE=8; keypad model drives row_n[r]=0
//   iff key(r,c) pressed and col_n[c]==0)
//  1 Reset, no keys -> outputs 0, col_n=1110; col_n steps 1110,1101,1011,0111,
//    then back to 1110, every 4 cycles.
//  2 Hold key(1,1) -> exactly one key_valid pulse, key_code=5, key_held=1,
//    col_n frozen at 1101.
//  3 Press key(0,3) for 5 cycles, then release -> no key_valid, key_code
//    unchanged, scan resumes at the next column.
//  4 In HELD, 3-cycle release glitch, then hold -> no second key_valid;
//    then release >=10 cycles -> key_held=0, scanning resumes.
//  5 Press each of the 16 keys in turn -> codes match the map table
//    (e.g. (3,0)=E, (3,1)=0, (3,3)=D).
//  6 Keys (0,2) and (2,2) together -> key_code=3.
//    Assert rst_n low mid-DEBOUNCE -> outputs reset at once, col_n=1110,
//    no key_valid.

Source files
------------

// File: rtl/keypad_scan_encoder.sv
// 4x4 matrix keypad scanner: synchronises the row inputs, walks the columns,
// debounces press and release, and encodes the accepted key into a 4-bit code.
module keypad_scan_encoder #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned MAX_CNT = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
    localparam int unsigned CW      = $clog2(MAX_CNT) + 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEB      = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    row_q, row_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic [3:0]    rows_s;
    logic          row_high;

    function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    assign rows_s    = sync2_q;
    assign row_high  = rows_s[row_q];
    assign col_n     = ~(4'b0001 << col_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

    always_comb begin
        sync1_d     = row_n;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_idx_d   = col_idx_q;
        row_d       = row_q;
        col_d       = col_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (rows_s != 4'hF) begin
                        // Lowest-index low row wins when several are pressed
                        if (!rows_s[0])      row_d = 2'd0;
                        else if (!rows_s[1]) row_d = 2'd1;
                        else if (!rows_s[2]) row_d = 2'd2;
                        else                 row_d = 2'd3;
                        col_d   = col_idx_q;
                        state_d = DEB;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEB: begin
                if (row_high) begin
                    state_d   = SCAN;
                    cnt_d     = '0;
                    col_idx_d = col_idx_q + 2'd1;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    key_code_d  = map_key(row_q, col_q);
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (row_high) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            default: begin
                // A bounce back to low returns to HELD without a new accept
                if (!row_high) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d    = SCAN;
                    cnt_d      = '0;
                    key_held_d = 1'b0;
                    col_idx_d  = col_idx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            col_idx_q   <= 2'd0;
            row_q       <= 2'd0;
            col_q       <= 2'd0;
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_idx_q   <= col_idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Bench for keypad_scan_encoder: a keypad model answers the column drive and
// expected key codes are queued at press time and matched on each key_valid.
module tb_keypad_scan_encoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed;
    logic [3:0]  exp_q[$];
    int          check_count = 0;
    int          pass_count  = 0;
    int          valid_count = 0;

    typedef struct {
        int         row;
        int         col;
        logic [3:0] code;
    } key_vec_t;

    key_vec_t vecs[16];

    keypad_scan_encoder #(
        .SCAN_DIV (4),
        .DEBOUNCE (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a row reads low when a pressed key sits in a driven column
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input int r, input int c, input logic down);
        pressed[r*4+c] = down;
    endtask

    // Scoreboard: every key_valid pops the oldest expected code
    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            valid_count++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_key_valid", exp_q.size(), 1);
            end else begin
                checkOutput("key_code_on_valid", key_code, exp_q.pop_front());
                checkOutput("held_with_valid", key_held, 1);
            end
        end
    end

    task automatic wait_valid(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_valid) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        checkOutput(name, seen, 1);
    endtask

    task automatic wait_held_low(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!key_held) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        checkOutput(name, seen, 1);
    endtask

    task automatic wait_fresh_col(input logic [3:0] pattern, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && col_n == pattern; i++) @(negedge clk);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (col_n == pattern) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        checkOutput("col_reached", seen, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] step_exp[4];
        int         vc;

        vecs[0]  = '{0, 0, 4'h1}; vecs[1]  = '{0, 1, 4'h2};
        vecs[2]  = '{0, 2, 4'h3}; vecs[3]  = '{0, 3, 4'hA};
        vecs[4]  = '{1, 0, 4'h4}; vecs[5]  = '{1, 1, 4'h5};
        vecs[6]  = '{1, 2, 4'h6}; vecs[7]  = '{1, 3, 4'hB};
        vecs[8]  = '{2, 0, 4'h7}; vecs[9]  = '{2, 1, 4'h8};
        vecs[10] = '{2, 2, 4'h9}; vecs[11] = '{2, 3, 4'hC};
        vecs[12] = '{3, 0, 4'hE}; vecs[13] = '{3, 1, 4'h0};
        vecs[14] = '{3, 2, 4'hF}; vecs[15] = '{3, 3, 4'hD};
        step_exp[0] = 4'b1101; step_exp[1] = 4'b1011;
        step_exp[2] = 4'b0111; step_exp[3] = 4'b1110;

        pressed = '0;
        rst_n   = 1'b0;

        // Reset state and the idle column walk
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_col_n", col_n, 4'b1110);
        checkOutput("reset_key_code", key_code, 4'h0);
        checkOutput("reset_key_valid", key_valid, 0);
        checkOutput("reset_key_held", key_held, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("col_dwell", col_n, 4'b1110);
        @(negedge clk);
        #1;
        checkOutput("col_step0", col_n, step_exp[0]);
        for (int k = 1; k < 4; k++) begin
            repeat (4) @(negedge clk);
            #1;
            checkOutput("col_step", col_n, step_exp[k]);
        end

        // Held key (1,1): one accept, column frozen while held
        exp_q.push_back(4'h5);
        applyStimulus(1, 1, 1'b1);
        wait_valid("accept_1_1", 100);
        vc = valid_count;
        repeat (20) @(negedge clk);
        #1;
        checkOutput("single_pulse_1_1", valid_count, vc);
        checkOutput("held_1_1", key_held, 1);
        checkOutput("col_frozen_1_1", col_n, 4'b1101);
        checkOutput("code_1_1", key_code, 4'h5);
        applyStimulus(1, 1, 1'b0);
        wait_held_low("release_1_1", 100);

        // Short press of (0,3) is rejected
        wait_fresh_col(4'b0111, 100);
        vc = valid_count;
        applyStimulus(0, 3, 1'b1);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("col_frozen_debounce", col_n, 4'b0111);
        applyStimulus(0, 3, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("abort_next_col", col_n, 4'b1110);
        repeat (20) @(negedge clk);
        #1;
        checkOutput("abort_no_valid", valid_count, vc);
        checkOutput("abort_code_kept", key_code, 4'h5);
        checkOutput("abort_not_held", key_held, 0);

        // Release glitch while held does not re-accept
        exp_q.push_back(4'h7);
        applyStimulus(2, 0, 1'b1);
        wait_valid("accept_2_0", 100);
        vc = valid_count;
        repeat (5) @(negedge clk);
        applyStimulus(2, 0, 1'b0);
        repeat (3) @(negedge clk);
        applyStimulus(2, 0, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        checkOutput("glitch_no_valid", valid_count, vc);
        checkOutput("glitch_still_held", key_held, 1);
        checkOutput("glitch_col_frozen", col_n, 4'b1110);
        applyStimulus(2, 0, 1'b0);
        repeat (10) @(negedge clk);
        wait_held_low("release_2_0", 50);
        wait_fresh_col(4'b1101, 40);

        // Every key in turn
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(vecs[i].code);
            applyStimulus(vecs[i].row, vecs[i].col, 1'b1);
            wait_valid("accept_table", 100);
            repeat (4) @(negedge clk);
            #1;
            checkOutput("table_code_held", key_code, vecs[i].code);
            applyStimulus(vecs[i].row, vecs[i].col, 1'b0);
            wait_held_low("release_table", 100);
        end

        // Two keys in one column: lowest row wins
        exp_q.push_back(4'h3);
        applyStimulus(0, 2, 1'b1);
        applyStimulus(2, 2, 1'b1);
        wait_valid("accept_multi", 100);
        applyStimulus(0, 2, 1'b0);
        applyStimulus(2, 2, 1'b0);
        wait_held_low("release_multi", 100);
        checkOutput("multi_code", key_code, 4'h3);

        // Reset in the middle of a debounce discards the press
        wait_fresh_col(4'b1011, 100);
        vc = valid_count;
        applyStimulus(1, 2, 1'b1);
        repeat (6) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_col_n", col_n, 4'b1110);
        checkOutput("midreset_key_code", key_code, 4'h0);
        checkOutput("midreset_key_valid", key_valid, 0);
        checkOutput("midreset_key_held", key_held, 0);
        applyStimulus(1, 2, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        checkOutput("midreset_no_valid", valid_count, vc);
        checkOutput("midreset_code_kept", key_code, 4'h0);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
